// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// The FSM state encoding lives here so the top level and the bench agree on it.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_NOBORROW = 2'd1,
        ST_BORROW   = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

endpackage

// File: rtl/serial_sub_cell.sv
// Combinational one-bit full subtractor: d = a - b - br, bo = borrow out.
module serial_sub_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_br,
    output logic o_d,
    output logic o_bo
);

    assign o_d  = i_a ^ i_b ^ i_br;
    assign o_bo = (~i_a & i_b) | (~(i_a ^ i_b) & i_br);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first. The incoming borrow is carried in the FSM
// state itself (NOBORROW/BORROW), so no separate borrow flop is needed.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             a,
    input  logic             b,
    output logic             ser_d,
    output logic             ser_v,
    output logic             busy,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             ovf,
    output logic             done
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-2:0]   r_shift;
    logic [WIDTH-1:0]   r_diff;
    logic               r_borrow;
    logic               r_ovf;
    logic               r_done;
    logic               r_ser_d;
    logic               r_ser_v;

    logic               w_br;
    logic               w_d;
    logic               w_bo;
    logic               w_last;
    logic [WIDTH-1:0]   w_full;
    logic [WIDTH-2:0]   w_shift_next;

    assign w_br   = (r_state == ST_BORROW);
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    serial_sub_cell u_cell (
        .i_a  (a),
        .i_b  (b),
        .i_br (w_br),
        .o_d  (w_d),
        .o_bo (w_bo)
    );

    // The newest bit is never stored: it goes straight into the top of the
    // assembled word, so WIDTH-1 flops hold everything consumed before it.
    assign w_full       = {w_d, r_shift};
    assign w_shift_next = w_full[WIDTH-1:1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_shift  <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
            r_ser_d  <= 1'b0;
            r_ser_v  <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_ser_v <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_NOBORROW;
                        r_cnt   <= '0;
                        r_shift <= '0;
                    end
                end
                ST_NOBORROW, ST_BORROW: begin
                    if (bit_valid) begin
                        r_ser_d <= w_d;
                        r_ser_v <= 1'b1;
                        r_shift <= w_shift_next;
                        if (w_last) begin
                            r_state  <= ST_DONE;
                            r_cnt    <= '0;
                            r_diff   <= w_full;
                            r_borrow <= w_bo;
                            // Signed overflow: operand signs differ and result sign differs from a.
                            r_ovf    <= (a != b) && (w_d != a);
                            r_done   <= 1'b1;
                        end else begin
                            r_cnt   <= r_cnt + CNT_W'(1);
                            r_state <= w_bo ? ST_BORROW : ST_NOBORROW;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = (r_state == ST_NOBORROW) || (r_state == ST_BORROW);
    assign ser_d      = r_ser_d;
    assign ser_v      = r_ser_v;
    assign diff       = r_diff;
    assign borrow_out = r_borrow;
    assign ovf        = r_ovf;
    assign done       = r_done;

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomised bench for serial_subtractor: words are checked against plain
// integer subtraction, unsigned compare and a signed range test.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         start;
    logic         bit_valid;
    logic         a;
    logic         b;
    logic         ser_d;
    logic         ser_v;
    logic         busy;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         ovf;
    logic         done;

    int n_vec;
    int n_err;

    logic [W-1:0] prev_diff;
    logic         prev_bo;
    logic         prev_ovf;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bit_valid  (bit_valid),
        .a          (a),
        .b          (b),
        .ser_d      (ser_d),
        .ser_v      (ser_v),
        .busy       (busy),
        .diff       (diff),
        .borrow_out (borrow_out),
        .ovf        (ovf),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: arithmetic on whole integers, not per-bit borrow chains.
    function automatic logic [W-1:0] ref_diff(input int unsigned av, input int unsigned bv);
        int unsigned r;
        r = (av + 256 - bv) % 256;
        return r[W-1:0];
    endfunction

    function automatic logic ref_ovf(input int unsigned av, input int unsigned bv);
        int sa;
        int sb;
        int r;
        sa = (av >= 128) ? int'(av) - 256 : int'(av);
        sb = (bv >= 128) ? int'(bv) - 256 : int'(bv);
        r  = sa - sb;
        return (r > 127) || (r < -128);
    endfunction

    // Runs one word; gap_mask inserts one stall before the flagged bit,
    // rand_gaps adds random stalls, start_bit re-pulses start with that bit.
    task automatic run_word(input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic [W-1:0] gap_mask, input bit rand_gaps,
                            input int start_bit, output int total);
        logic [W-1:0] exp_d;
        logic         exp_bo;
        logic         exp_ovf;
        int           nst;
        int           k;
        exp_d   = ref_diff(av, bv);
        exp_bo  = (av < bv);
        exp_ovf = ref_ovf(av, bv);
        total   = 0;

        start     = 1'b1;
        bit_valid = 1'b0;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("serv_after_start", ser_v, 0);

        for (int idx = 0; idx < W; idx++) begin
            nst = gap_mask[idx] ? 1 : 0;
            if (rand_gaps && ($urandom_range(0, 7) == 0))
                nst += $urandom_range(1, 2);
            for (int s = 0; s < nst; s++) begin
                bit_valid = 1'b0;
                a = 1'($urandom);
                b = 1'($urandom);
                tick();
                total++;
                check("serv_stall", ser_v, 0);
                check("done_stall", done, 0);
                check("busy_stall", busy, 1);
            end
            bit_valid = 1'b1;
            a = av[idx];
            b = bv[idx];
            start = (idx == start_bit);
            tick();
            total++;
            start     = 1'b0;
            bit_valid = 1'b0;
            check("serv_bit", ser_v, 1);
            check("serd_bit", ser_d, exp_d[idx]);
            if (idx < W - 1) begin
                check("done_early", done, 0);
                check("diff_hold", diff, prev_diff);
                check("bo_hold", borrow_out, prev_bo);
                check("ovf_hold", ovf, prev_ovf);
            end
        end

        k = 0;
        while (!done && k < 4) begin
            tick();
            k++;
        end
        total += k;
        check("done_latency", k, 0);
        check("diff", diff, exp_d);
        check("borrow_out", borrow_out, exp_bo);
        check("ovf", ovf, exp_ovf);
        check("busy_done", busy, 0);
        tick();
        check("done_pulse", done, 0);
        check("busy_idle", busy, 0);
        check("serv_idle", ser_v, 0);
        check("diff_after", diff, exp_d);
        prev_diff = exp_d;
        prev_bo   = exp_bo;
        prev_ovf  = exp_ovf;
    endtask

    initial begin
        int tot;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        start = 1'b0;
        bit_valid = 1'b0;
        a = 1'b0;
        b = 1'b0;
        prev_diff = '0;
        prev_bo   = 1'b0;
        prev_ovf  = 1'b0;

        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_bo", borrow_out, 0);
        check("rst_ovf", ovf, 0);
        check("rst_serv", ser_v, 0);
        check("rst_serd", ser_d, 0);
        reset = 1'b1;
        tick();

        // bit_valid while idle must not start anything or emit bits
        bit_valid = 1'b1;
        a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_serv", ser_v, 0);
            check("idle_busy", busy, 0);
        end
        bit_valid = 1'b0;
        $display("idle bit_valid ignored");

        run_word(8'h05, 8'h03, 8'h00, 1'b0, -1, tot);
        check("lat_nogap", tot, W);
        $display("word a=05 b=03 diff=%0h bo=%0b ovf=%0b", diff, borrow_out, ovf);

        run_word(8'h03, 8'h05, 8'h00, 1'b0, -1, tot);
        $display("word a=03 b=05 diff=%0h bo=%0b ovf=%0b", diff, borrow_out, ovf);

        run_word(8'h80, 8'h01, 8'b0010_0100, 1'b0, -1, tot);
        check("lat_gaps", tot, W + 2);
        $display("word a=80 b=01 gaps diff=%0h bo=%0b ovf=%0b", diff, borrow_out, ovf);

        run_word(8'h5A, 8'hC3, 8'h00, 1'b0, 3, tot);
        check("lat_midstart", tot, W);
        $display("word a=5a b=c3 start@bit3 diff=%0h", diff);

        // abort after 4 bits; reset also wins over start/bit_valid
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bit_valid = 1'b1;
            a = 1'b1;
            b = 1'b0;
            tick();
        end
        reset = 1'b0;
        start = 1'b1;
        bit_valid = 1'b1;
        tick();
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_diff", diff, 0);
        check("abort_bo", borrow_out, 0);
        check("abort_ovf", ovf, 0);
        check("abort_serv", ser_v, 0);
        check("abort_serd", ser_d, 0);
        reset = 1'b1;
        start = 1'b0;
        tick();
        check("abort_norestart", busy, 0);
        check("abort_nodone", done, 0);
        bit_valid = 1'b0;
        prev_diff = '0;
        prev_bo   = 1'b0;
        prev_ovf  = 1'b0;
        run_word(8'hFF, 8'hFF, 8'h00, 1'b0, -1, tot);
        $display("word after abort a=ff b=ff diff=%0h bo=%0b ovf=%0b", diff, borrow_out, ovf);

        for (int n = 0; n < 6000; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            run_word(ra, rb, 8'h00, 1'b1, -1, tot);
            if (n % 1000 == 0)
                $display("random word %0d a=%0h b=%0h diff=%0h", n, ra, rb, diff);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
